// File: rtl/shift_pkg.sv
// Shared definitions for the sequential left shifter.
//   state_t : controller states (IDLE, SHIFT, DONE)
//   log2n() : number of shift stages for an N-bit operand
package shift_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  function automatic int log2n(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/mux_2_1.sv
// One-bit 2:1 multiplexer.
//   d0 : selected when s=0
//   d1 : selected when s=1
//   s  : select
//   y  : output
module mux_2_1 (
  input  logic d0,
  input  logic d1,
  input  logic s,
  output logic y
);

  assign y = s ? d1 : d0;

endmodule

// File: rtl/shift_left_seq.sv
// Sequential logical left shifter: one binary-weighted stage per clock,
// LOG2N stages total, so latency is fixed regardless of the shift amount.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   start : request; accepted in IDLE or DONE
//   a     : operand, sampled on accept
//   b     : unsigned shift amount, sampled on accept
//   out   : registered result (a << b, zero fill; 0 when b >= N)
//   busy  : high while stages are being applied
//   done  : one-cycle pulse when out has just been updated
module shift_left_seq
  import shift_pkg::*;
#(
  parameter int N     = 8,
  parameter int LOG2N = log2n(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] out,
  output logic         busy,
  output logic         done
);

  localparam logic [LOG2N-1:0] LAST = LOG2N'(LOG2N - 1);

  state_t             state, nxt;
  logic [N-1:0]       acc, shifted, stage;
  logic [LOG2N-1:0]   shamt, shamt_sh, cnt;
  logic               ovf, sel, accept, last;
  logic [N-1:0]       bhi;

  // Any set bit above the stage-select bits means the shift clears everything.
  assign bhi      = b >> LOG2N;

  // Stage cnt shifts by 2**cnt when bit cnt of the amount is set.
  assign shamt_sh = shamt >> cnt;
  assign sel      = shamt_sh[0];
  assign shifted  = acc << (32'd1 << cnt);

  // Per-bit select: keep acc[j], or take acc[j - 2**cnt] (zero below that).
  for (genvar j = 0; j < N; j++) begin : g_mux
    mux_2_1 u_mux (
      .d0 (acc[j]),
      .d1 (shifted[j]),
      .s  (sel),
      .y  (stage[j])
    );
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // Next-state and status outputs
  always_comb begin
    nxt    = state;
    busy   = 1'b0;
    done   = 1'b0;
    accept = 1'b0;
    last   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
          nxt    = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == LAST) begin
          last = 1'b1;
          nxt  = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept = 1'b1;
          nxt    = SHIFT;
        end else begin
          nxt    = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      shamt <= '0;
      ovf   <= 1'b0;
      cnt   <= '0;
      out   <= '0;
    end else if (accept) begin
      acc   <= a;
      shamt <= b[LOG2N-1:0];
      ovf   <= |bhi;
      cnt   <= '0;
    end else if (state == SHIFT) begin
      acc <= stage;
      cnt <= cnt + LOG2N'(1);
      if (last) out <= ovf ? '0 : stage;
    end
  end

endmodule
